// File: rtl/rvh_l1d_req_arb.sv
// L1D request entry: fixed-priority (PTW > store > load) arbiter into one registered slot, with load starvation override.
// Latency 1 cycle (handshake in N, slot valid in N+1); the slot accepts when it is empty or out_rdy_i=1, else every rdy_o stays low.
module rvh_l1d_req_arb #(
    parameter int unsigned PADDR_WIDTH  = 56,
    parameter int unsigned XLEN         = 64,
    parameter int unsigned TAG_WIDTH    = 8,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ld_req_vld_i,
    output logic                   ld_req_rdy_o,
    input  logic [3:0]             ld_req_opcode_i,
    input  logic [PADDR_WIDTH-1:0] ld_req_paddr_i,
    input  logic [TAG_WIDTH-1:0]   ld_req_tag_i,
    input  logic                   st_req_vld_i,
    output logic                   st_req_rdy_o,
    input  logic [4:0]             st_req_opcode_i,
    input  logic [PADDR_WIDTH-1:0] st_req_paddr_i,
    input  logic [XLEN-1:0]        st_req_data_i,
    input  logic [TAG_WIDTH-1:0]   st_req_tag_i,
    input  logic                   ptw_req_vld_i,
    output logic                   ptw_req_rdy_o,
    input  logic [PADDR_WIDTH-1:0] ptw_req_paddr_i,
    input  logic                   flush_i,
    input  logic                   out_rdy_i,
    output logic                   is_ld_req_vld_o,
    output logic                   is_st_req_vld_o,
    output logic                   is_ptw_req_vld_o,
    output logic [3:0]             ld_req_opcode_o,
    output logic [4:0]             st_req_opcode_o,
    output logic [PADDR_WIDTH-1:0] paddr_o,
    output logic [XLEN-1:0]        data_o,
    output logic [TAG_WIDTH-1:0]   tag_o,
    output logic                   illegal_op_o
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic                   is_ld_q, is_ld_d;
    logic                   is_st_q, is_st_d;
    logic                   is_ptw_q, is_ptw_d;
    logic [3:0]             ld_op_q, ld_op_d;
    logic [4:0]             st_op_q, st_op_d;
    logic [PADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [XLEN-1:0]        data_q, data_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic                   illegal_q, illegal_d;
    logic [CNT_W-1:0]       starve_cnt_q, starve_cnt_d;

    logic slot_vld, accept, ld_ovr;
    logic grant_ld, grant_st, grant_ptw;
    logic ld_legal, st_legal;

    assign slot_vld = is_ld_q | is_st_q | is_ptw_q;
    assign accept   = rst_n & (~slot_vld | out_rdy_i);
    assign ld_legal = (ld_req_opcode_i <= 4'd8);
    assign st_legal = (st_req_opcode_i != 5'd4) && (st_req_opcode_i <= 5'd24);

    // A flushed load can't win, so the override only applies when the load is grantable.
    assign ld_ovr    = ld_req_vld_i & ~flush_i & (starve_cnt_q == CNT_MAX);
    assign grant_ptw = accept & ptw_req_vld_i & ~ld_ovr;
    assign grant_st  = accept & st_req_vld_i & ~ptw_req_vld_i & ~ld_ovr;
    assign grant_ld  = accept & ld_req_vld_i & ~flush_i &
                       (ld_ovr | (~ptw_req_vld_i & ~st_req_vld_i));

    assign ptw_req_rdy_o = grant_ptw;
    assign st_req_rdy_o  = grant_st;
    assign ld_req_rdy_o  = grant_ld;

    always_comb begin
        is_ld_d      = is_ld_q;
        is_st_d      = is_st_q;
        is_ptw_d     = is_ptw_q;
        ld_op_d      = ld_op_q;
        st_op_d      = st_op_q;
        paddr_d      = paddr_q;
        data_d       = data_q;
        tag_d        = tag_q;
        illegal_d    = (grant_ld & ~ld_legal) | (grant_st & ~st_legal);
        starve_cnt_d = starve_cnt_q;

        // Drained or flushed slots are zeroed so outputs read 0 when not valid.
        if (slot_vld && (out_rdy_i || (flush_i && is_ld_q))) begin
            is_ld_d  = 1'b0;
            is_st_d  = 1'b0;
            is_ptw_d = 1'b0;
            ld_op_d  = '0;
            st_op_d  = '0;
            paddr_d  = '0;
            data_d   = '0;
            tag_d    = '0;
        end

        if (grant_ptw) begin
            is_ld_d  = 1'b0;
            is_st_d  = 1'b0;
            is_ptw_d = 1'b1;
            ld_op_d  = '0;
            st_op_d  = '0;
            paddr_d  = ptw_req_paddr_i;
            data_d   = '0;
            tag_d    = '0;
        end else if (grant_st && st_legal) begin
            is_ld_d  = 1'b0;
            is_st_d  = 1'b1;
            is_ptw_d = 1'b0;
            ld_op_d  = '0;
            st_op_d  = st_req_opcode_i;
            paddr_d  = st_req_paddr_i;
            data_d   = st_req_data_i;
            tag_d    = st_req_tag_i;
        end else if (grant_ld && ld_legal) begin
            is_ld_d  = 1'b1;
            is_st_d  = 1'b0;
            is_ptw_d = 1'b0;
            ld_op_d  = ld_req_opcode_i;
            st_op_d  = '0;
            paddr_d  = ld_req_paddr_i;
            data_d   = '0;
            tag_d    = ld_req_tag_i;
        end

        if (!ld_req_vld_i || grant_ld) begin
            starve_cnt_d = '0;
        end else if (accept && !flush_i && starve_cnt_q != CNT_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_ld_q      <= 1'b0;
            is_st_q      <= 1'b0;
            is_ptw_q     <= 1'b0;
            ld_op_q      <= '0;
            st_op_q      <= '0;
            paddr_q      <= '0;
            data_q       <= '0;
            tag_q        <= '0;
            illegal_q    <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            is_ld_q      <= is_ld_d;
            is_st_q      <= is_st_d;
            is_ptw_q     <= is_ptw_d;
            ld_op_q      <= ld_op_d;
            st_op_q      <= st_op_d;
            paddr_q      <= paddr_d;
            data_q       <= data_d;
            tag_q        <= tag_d;
            illegal_q    <= illegal_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign is_ld_req_vld_o  = is_ld_q;
    assign is_st_req_vld_o  = is_st_q;
    assign is_ptw_req_vld_o = is_ptw_q;
    assign ld_req_opcode_o  = ld_op_q;
    assign st_req_opcode_o  = st_op_q;
    assign paddr_o          = paddr_q;
    assign data_o           = data_q;
    assign tag_o            = tag_q;
    assign illegal_op_o     = illegal_q;

endmodule

// File: tb/tb_rvh_l1d_req_arb.sv
// Directed bench for rvh_l1d_req_arb: priority order, starvation override, stall, flush, illegal opcodes, reset.
module tb_rvh_l1d_req_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_req_vld_i, ld_req_rdy_o;
    logic [3:0]  ld_req_opcode_i;
    logic [55:0] ld_req_paddr_i;
    logic [7:0]  ld_req_tag_i;
    logic        st_req_vld_i, st_req_rdy_o;
    logic [4:0]  st_req_opcode_i;
    logic [55:0] st_req_paddr_i;
    logic [63:0] st_req_data_i;
    logic [7:0]  st_req_tag_i;
    logic        ptw_req_vld_i, ptw_req_rdy_o;
    logic [55:0] ptw_req_paddr_i;
    logic        flush_i, out_rdy_i;
    logic        is_ld_req_vld_o, is_st_req_vld_o, is_ptw_req_vld_o;
    logic [3:0]  ld_req_opcode_o;
    logic [4:0]  st_req_opcode_o;
    logic [55:0] paddr_o;
    logic [63:0] data_o;
    logic [7:0]  tag_o;
    logic        illegal_op_o;

    int n_checks = 0;
    int n_errors = 0;

    rvh_l1d_req_arb dut (
        .clk(clk), .rst_n(rst_n),
        .ld_req_vld_i(ld_req_vld_i), .ld_req_rdy_o(ld_req_rdy_o),
        .ld_req_opcode_i(ld_req_opcode_i), .ld_req_paddr_i(ld_req_paddr_i),
        .ld_req_tag_i(ld_req_tag_i),
        .st_req_vld_i(st_req_vld_i), .st_req_rdy_o(st_req_rdy_o),
        .st_req_opcode_i(st_req_opcode_i), .st_req_paddr_i(st_req_paddr_i),
        .st_req_data_i(st_req_data_i), .st_req_tag_i(st_req_tag_i),
        .ptw_req_vld_i(ptw_req_vld_i), .ptw_req_rdy_o(ptw_req_rdy_o),
        .ptw_req_paddr_i(ptw_req_paddr_i),
        .flush_i(flush_i), .out_rdy_i(out_rdy_i),
        .is_ld_req_vld_o(is_ld_req_vld_o), .is_st_req_vld_o(is_st_req_vld_o),
        .is_ptw_req_vld_o(is_ptw_req_vld_o),
        .ld_req_opcode_o(ld_req_opcode_o), .st_req_opcode_o(st_req_opcode_o),
        .paddr_o(paddr_o), .data_o(data_o), .tag_o(tag_o),
        .illegal_op_o(illegal_op_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // {ptw, st, ld} rdy as one 3-bit value.
    function automatic logic [2:0] rdys();
        return {ptw_req_rdy_o, st_req_rdy_o, ld_req_rdy_o};
    endfunction

    function automatic logic [2:0] vlds();
        return {is_ptw_req_vld_o, is_st_req_vld_o, is_ld_req_vld_o};
    endfunction

    initial begin
        rst_n = 1'b0;
        ld_req_vld_i = 1'b1; ld_req_opcode_i = 4'd0; ld_req_paddr_i = '0; ld_req_tag_i = '0;
        st_req_vld_i = 1'b1; st_req_opcode_i = 5'd1; st_req_paddr_i = '0;
        st_req_data_i = '0; st_req_tag_i = '0;
        ptw_req_vld_i = 1'b1; ptw_req_paddr_i = '0;
        flush_i = 1'b0; out_rdy_i = 1'b1;

        // Reset state, with requests pending: no rdy while in reset.
        tick();
        tick();
        settle();
        check("rst_rdy", 64'(rdys()), 64'd0);
        check("rst_vld", 64'(vlds()), 64'd0);
        check("rst_ill", 64'(illegal_op_o), 64'd0);
        check("rst_paddr", 64'(paddr_o), 64'd0);
        ld_req_vld_i = 1'b0; st_req_vld_i = 1'b0; ptw_req_vld_i = 1'b0;
        rst_n = 1'b1;

        // Priority: all three valid together -> PTW, store, load in consecutive cycles.
        tick();
        ptw_req_vld_i = 1'b1; ptw_req_paddr_i = 56'h100;
        st_req_vld_i = 1'b1; st_req_paddr_i = 56'h200; st_req_opcode_i = 5'd7;
        st_req_data_i = 64'hDEAD_BEEF_0123_4567; st_req_tag_i = 8'h11;
        ld_req_vld_i = 1'b1; ld_req_paddr_i = 56'h300; ld_req_opcode_i = 4'd3; ld_req_tag_i = 8'h22;
        settle();
        check("pri_rdy_ptw", 64'(rdys()), 64'b100);
        tick();
        ptw_req_vld_i = 1'b0;
        check("pri_slot_ptw", 64'(vlds()), 64'b100);
        check("pri_paddr_ptw", 64'(paddr_o), 64'h100);
        check("pri_tag_ptw", 64'(tag_o), 64'h0);
        settle();
        check("pri_rdy_st", 64'(rdys()), 64'b010);
        tick();
        st_req_vld_i = 1'b0;
        check("pri_slot_st", 64'(vlds()), 64'b010);
        check("pri_paddr_st", 64'(paddr_o), 64'h200);
        check("pri_data_st", data_o, 64'hDEAD_BEEF_0123_4567);
        check("pri_op_st", 64'({ld_req_opcode_o, st_req_opcode_o}), 64'({4'd0, 5'd7}));
        settle();
        check("pri_rdy_ld", 64'(rdys()), 64'b001);
        tick();
        ld_req_vld_i = 1'b0;
        check("pri_slot_ld", 64'(vlds()), 64'b001);
        check("pri_paddr_ld", 64'(paddr_o), 64'h300);
        check("pri_op_ld", 64'({ld_req_opcode_o, st_req_opcode_o}), 64'({4'd3, 5'd0}));
        check("pri_data_ld", data_o, 64'd0);
        tick();
        check("drain_empty", 64'(vlds()), 64'd0);

        // Starvation: load loses 8 accepting cycles to the store, wins the 9th.
        st_req_vld_i = 1'b1; ld_req_vld_i = 1'b1; ld_req_paddr_i = 56'h310;
        for (int i = 1; i <= 8; i++) begin
            settle();
            check($sformatf("starve_lose%0d", i), 64'(rdys()), 64'b010);
            tick();
        end
        check("starve_cnt_sat", 64'(dut.starve_cnt_q), 64'd8);
        settle();
        check("starve_win", 64'(rdys()), 64'b001);
        tick();
        ld_req_vld_i = 1'b0;
        check("starve_slot_ld", 64'(vlds()), 64'b001);
        check("starve_paddr", 64'(paddr_o), 64'h310);
        check("starve_cnt_clr", 64'(dut.starve_cnt_q), 64'd0);
        settle();
        check("starve_st_next", 64'(rdys()), 64'b010);
        tick();
        st_req_vld_i = 1'b0;

        // Stall: store held 5 cycles with a load pending, then the load enters.
        out_rdy_i = 1'b0; ld_req_vld_i = 1'b1; ld_req_paddr_i = 56'h340; ld_req_opcode_i = 4'd8;
        for (int i = 0; i < 5; i++) begin
            settle();
            check($sformatf("stall_rdy%0d", i), 64'(rdys()), 64'd0);
            check($sformatf("stall_vld%0d", i), 64'(vlds()), 64'b010);
            check($sformatf("stall_paddr%0d", i), 64'(paddr_o), 64'h200);
            tick();
        end
        out_rdy_i = 1'b1;
        settle();
        check("stall_release", 64'(rdys()), 64'b001);
        tick();
        ld_req_vld_i = 1'b0;
        check("stall_slot_ld", 64'(vlds()), 64'b001);
        check("stall_paddr_ld", 64'(paddr_o), 64'h340);
        check("stall_op_ld", 64'(ld_req_opcode_o), 64'd8);

        // Flush kills the held load; store still granted during flush once the slot frees.
        out_rdy_i = 1'b0; flush_i = 1'b1;
        st_req_vld_i = 1'b1; st_req_paddr_i = 56'h400; st_req_opcode_i = 5'd5;
        settle();
        check("flush_rdy_full", 64'(rdys()), 64'd0);
        tick();
        check("flush_kill", 64'(vlds()), 64'd0);
        ld_req_vld_i = 1'b1;
        settle();
        check("flush_st_grant", 64'(rdys()), 64'b010);
        tick();
        st_req_vld_i = 1'b0; ld_req_vld_i = 1'b0; flush_i = 1'b0; out_rdy_i = 1'b1;
        check("flush_st_slot", 64'(vlds()), 64'b010);
        check("flush_st_paddr", 64'(paddr_o), 64'h400);
        tick();

        // Illegal store opcode 4: handshake, no slot write, one-cycle pulse.
        st_req_vld_i = 1'b1; st_req_opcode_i = 5'd4;
        settle();
        check("ill_st_rdy", 64'(rdys()), 64'b010);
        tick();
        st_req_vld_i = 1'b0;
        check("ill_st_slot", 64'(vlds()), 64'd0);
        check("ill_st_pulse", 64'(illegal_op_o), 64'd1);
        tick();
        check("ill_st_pulse_end", 64'(illegal_op_o), 64'd0);

        // Illegal load opcode 9 while a store drains: slot goes empty.
        st_req_vld_i = 1'b1; st_req_opcode_i = 5'd24;
        tick();
        st_req_vld_i = 1'b0;
        check("ill_ld_prev_st", 64'(vlds()), 64'b010);
        ld_req_vld_i = 1'b1; ld_req_opcode_i = 4'd9;
        settle();
        check("ill_ld_rdy", 64'(rdys()), 64'b001);
        tick();
        ld_req_vld_i = 1'b0;
        check("ill_ld_slot", 64'(vlds()), 64'd0);
        check("ill_ld_pulse", 64'(illegal_op_o), 64'd1);
        tick();
        check("ill_ld_pulse_end", 64'(illegal_op_o), 64'd0);

        // Reset mid-operation: full slot and nonzero starve count are cleared.
        st_req_vld_i = 1'b1; st_req_opcode_i = 5'd2; st_req_paddr_i = 56'h500;
        ld_req_vld_i = 1'b1; ld_req_opcode_i = 4'd1;
        tick();
        st_req_vld_i = 1'b0; out_rdy_i = 1'b0;
        check("mid_slot_st", 64'(vlds()), 64'b010);
        check("mid_cnt", 64'(dut.starve_cnt_q), 64'd1);
        rst_n = 1'b0;
        settle();
        check("mid_rst_rdy", 64'(rdys()), 64'd0);
        tick();
        check("mid_rst_vld", 64'(vlds()), 64'd0);
        check("mid_rst_paddr", 64'(paddr_o), 64'd0);
        check("mid_rst_data", data_o, 64'd0);
        check("mid_rst_op", 64'({ld_req_opcode_o, st_req_opcode_o}), 64'd0);
        check("mid_rst_cnt", 64'(dut.starve_cnt_q), 64'd0);
        rst_n = 1'b1; ld_req_vld_i = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
